// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter for the bit-serial input of the
// Mealy sequence detectors. It captures a pattern of up to MAX_LEN bits and
// sends it MSB-first with a valid/ready handshake. The pattern can repeat
// back-to-back or with idle gap cycles between repetitions.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      begin a transmission (sampled only while idle)
//   pattern    pattern bits; bit [len-1] is sent first, bit [0] last
//   len        number of pattern bits, legal range 1..MAX_LEN
//   repeats    extra repetitions; total sends = repeats + 1
//   gap        idle cycles between repetitions (0 = back-to-back)
//   ready      sink accepts data_out this cycle
//   data_out   serial bit (IDLE_BIT when data_valid = 0)
//   data_valid data_out carries a pattern bit
//   sof        first bit of a repetition, qualified by data_valid
//   busy       transmission in progress (SEND or GAP)
//   done       one-cycle pulse after the final bit is accepted
//   err        one-cycle pulse when start is rejected for an illegal len
module seq_pattern_gen #(
    parameter int unsigned MAX_LEN  = 8,
    parameter int unsigned LEN_W    = 5,
    parameter int unsigned REP_W    = 4,
    parameter int unsigned GAP_W    = 4,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   repeats,
    input  logic [GAP_W-1:0]   gap,
    input  logic               ready,
    output logic               data_out,
    output logic               data_valid,
    output logic               sof,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned      IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state;
    logic [MAX_LEN-1:0] pat_q;
    logic [IDX_W-1:0]   top_idx_q;   // len-1 of the captured pattern
    logic [IDX_W-1:0]   idx;         // index of the bit currently presented
    logic [REP_W-1:0]   rep_left;    // repetitions still to send after this one
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt;     // remaining gap cycles, including the current one

    logic               len_ok;
    logic [IDX_W-1:0]   start_idx;
    logic [IDX_W-1:0]   next_idx;
    logic               xfer;

    // Request qualification and index arithmetic used by the FSM.
    assign len_ok    = (len != '0) && (len <= MAX_LEN_L);
    assign start_idx = IDX_W'(len - LEN_W'(1));
    assign next_idx  = idx - IDX_W'(1);
    assign xfer      = data_valid && ready;

    // Single registered FSM; every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pat_q      <= '0;
            top_idx_q  <= '0;
            idx        <= '0;
            rep_left   <= '0;
            gap_q      <= '0;
            gap_cnt    <= '0;
            data_out   <= IDLE_BIT;
            data_valid <= 1'b0;
            sof        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            pat_q      <= pattern;
                            top_idx_q  <= start_idx;
                            idx        <= start_idx;
                            rep_left   <= repeats;
                            gap_q      <= gap;
                            data_out   <= pattern[start_idx];
                            data_valid <= 1'b1;
                            sof        <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_SEND;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                S_SEND: begin
                    // Without a transfer, data_out, sof and idx simply hold.
                    if (xfer) begin
                        if (idx != '0) begin
                            idx      <= next_idx;
                            data_out <= pat_q[next_idx];
                            sof      <= 1'b0;
                        end else if (rep_left != '0) begin
                            rep_left <= rep_left - REP_W'(1);
                            if (gap_q == '0) begin
                                idx      <= top_idx_q;
                                data_out <= pat_q[top_idx_q];
                                sof      <= 1'b1;
                            end else begin
                                gap_cnt    <= gap_q;
                                data_out   <= IDLE_BIT;
                                data_valid <= 1'b0;
                                sof        <= 1'b0;
                                state      <= S_GAP;
                            end
                        end else begin
                            data_out   <= IDLE_BIT;
                            data_valid <= 1'b0;
                            sof        <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                end

                S_GAP: begin
                    // Counts idle cycles regardless of ready.
                    if (gap_cnt == GAP_W'(1)) begin
                        idx        <= top_idx_q;
                        data_out   <= pat_q[top_idx_q];
                        data_valid <= 1'b1;
                        sof        <= 1'b1;
                        state      <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                default: begin
                    data_out   <= IDLE_BIT;
                    data_valid <= 1'b0;
                    sof        <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
